// File: rtl/clock_time_ctrl.sv
// Timekeeping core: 1 s prescaler driving an hh:mm:ss counter, plus a
// RUN / SET_HR / SET_MIN mode FSM driven by two synchronised push-buttons.
module clock_time_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       tick_1hz,
    output logic       blink
);

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;
    logic [1:0]    mode_sync, inc_sync;
    logic          mode_prev, inc_prev;
    logic          mode_pulse, inc_pulse;

    // Two-flop synchroniser followed by a rising-edge detector per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= '0;
            inc_sync  <= '0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
            mode_prev <= mode_sync[1];
            inc_prev  <= inc_sync[1];
        end
    end

    assign mode_pulse = mode_sync[1] & ~mode_prev;
    // A mode press in the same cycle swallows the increment.
    assign inc_pulse  = inc_sync[1] & ~inc_prev & ~mode_pulse;

    assign mode = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            presc    <= '0;
            bcnt     <= '0;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            tick_1hz <= 1'b0;
            blink    <= 1'b0;
        end else begin
            tick_1hz <= 1'b0;
            case (state)
                RUN: begin
                    blink <= 1'b0;
                    bcnt  <= '0;
                    if (mode_pulse) begin
                        state <= SET_HR;
                        presc <= '0;
                        blink <= 1'b1;
                    end else if (presc == PMAX) begin
                        presc    <= '0;
                        tick_1hz <= 1'b1;
                        if (seconds == 6'd59) begin
                            seconds <= '0;
                            if (minutes == 6'd59) begin
                                minutes <= '0;
                                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                            end else begin
                                minutes <= minutes + 6'd1;
                            end
                        end else begin
                            seconds <= seconds + 6'd1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                SET_HR, SET_MIN: begin
                    presc <= '0;
                    if (mode_pulse) begin
                        bcnt <= '0;
                        if (state == SET_HR) begin
                            state <= SET_MIN;
                            blink <= 1'b1;
                        end else begin
                            // Restart the second so the first tick is a full period away.
                            state   <= RUN;
                            seconds <= '0;
                            blink   <= 1'b0;
                        end
                    end else begin
                        if (bcnt == BMAX) begin
                            bcnt  <= '0;
                            blink <= ~blink;
                        end else begin
                            bcnt <= bcnt + BW'(1);
                        end
                        if (inc_pulse) begin
                            if (state == SET_HR)
                                hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                            else
                                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    presc <= '0;
                    bcnt  <= '0;
                    blink <= 1'b0;
                end
            endcase
        end
    end

endmodule
